// File: rtl/tx_gear_sc_pkg.sv
// Shared definitions for the Tx gearbox: lane width default, idle symbol and
// the state encoding used by the top-level sequencer.
package tx_gear_sc_pkg;

    localparam int unsigned GWIDTH_DEFAULT = 14;

    // Lane word driven whenever the gearbox is not streaming; bit 1 is TxElecIdle.
    localparam logic [GWIDTH_DEFAULT-1:0] IDLE_WORD_DEFAULT = 14'h0002;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } gear_state_e;

endpackage

// File: rtl/tx_gear_fifo.sv
// Small register-file FIFO holding full 2*GWIDTH words for the Tx gearbox.
// The head entry is readable combinationally so a word can be split onto the
// lane in the same cycle it is popped. A flush empties the FIFO in one cycle.
module tx_gear_fifo #(
    parameter int DW    = 28,
    parameter int DEPTH = 4
) (
    input  logic                       clk_250,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wr_data,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [DW-1:0] entries [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;
    assign rd_data = entries[rd_ptr_reg];

    // One storage register per entry, written when the write pointer selects it
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [DW-1:0] entry_reg;

        // Capture the incoming word into this slot
        always_ff @(posedge clk_250) begin
            if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                entry_reg <= wr_data;
            end
        end

        assign entries[gi] = entry_reg;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_250) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tx_gear_sc.sv
// Tx gearbox: accepts 2*GWIDTH-bit words at half rate and serialises each one
// as two GWIDTH-bit lane symbols (high half first). Streaming starts only once
// FILL_LVL words are buffered, and only whole words are ever put on the lane.
module tx_gear_sc
    import tx_gear_sc_pkg::*;
#(
    parameter int                GWIDTH    = GWIDTH_DEFAULT,
    parameter int                DEPTH     = 4,
    parameter int                FILL_LVL  = 2,
    parameter logic [GWIDTH-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
    input  logic                clk_250,
    input  logic                rst_n,
    input  logic                drate_enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*GWIDTH-1:0] data_in,
    output logic [GWIDTH-1:0]   data_out,
    output logic                out_active,
    output logic                underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FILL_CNT = (AW+1)'(FILL_LVL);

    logic                drate_meta_reg;
    logic                drate_s_reg;
    gear_state_e         state_reg;
    logic                phase_reg;
    logic [GWIDTH-1:0]   data_out_reg;
    logic [GWIDTH-1:0]   lane_lo_reg;
    logic                out_active_reg;
    logic                underflow_reg;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*GWIDTH-1:0] fifo_head;
    logic [AW:0]         fifo_count;

    // Bring the asynchronous gear enable into the lane clock domain
    always_ff @(posedge clk_250) begin
        if (!rst_n) begin
            drate_meta_reg <= 1'b0;
            drate_s_reg    <= 1'b0;
        end else begin
            drate_meta_reg <= drate_enable;
            drate_s_reg    <= drate_meta_reg;
        end
    end

    // A full FIFO refuses data even if a pop happens in the same cycle
    assign in_ready  = (state_reg != ST_IDLE) && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = drate_s_reg && (state_reg == ST_RUN) && !phase_reg && !fifo_empty;

    tx_gear_fifo #(
        .DW    (2*GWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_250 (clk_250),
        .rst_n   (rst_n),
        .flush   (!drate_s_reg),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (data_in),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sequencer, phase flop and lane output register
    always_ff @(posedge clk_250) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            phase_reg      <= 1'b0;
            data_out_reg   <= IDLE_WORD;
            lane_lo_reg    <= '0;
            out_active_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            underflow_reg <= 1'b0;
            if (!drate_s_reg) begin
                // Gear disabled: drop everything, including a pending low half
                state_reg      <= ST_IDLE;
                phase_reg      <= 1'b0;
                data_out_reg   <= IDLE_WORD;
                out_active_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg      <= ST_FILL;
                        phase_reg      <= 1'b0;
                        data_out_reg   <= IDLE_WORD;
                        out_active_reg <= 1'b0;
                    end
                    ST_FILL: begin
                        phase_reg      <= 1'b0;
                        data_out_reg   <= IDLE_WORD;
                        out_active_reg <= 1'b0;
                        if (fifo_count >= FILL_CNT) begin
                            state_reg <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (phase_reg) begin
                            data_out_reg   <= lane_lo_reg;
                            out_active_reg <= 1'b1;
                            phase_reg      <= 1'b0;
                        end else if (!fifo_empty) begin
                            data_out_reg   <= fifo_head[2*GWIDTH-1:GWIDTH];
                            lane_lo_reg    <= fifo_head[GWIDTH-1:0];
                            out_active_reg <= 1'b1;
                            phase_reg      <= 1'b1;
                        end else begin
                            // Starved at a word boundary: go back to refilling
                            data_out_reg   <= IDLE_WORD;
                            out_active_reg <= 1'b0;
                            underflow_reg  <= 1'b1;
                            state_reg      <= ST_FILL;
                            phase_reg      <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg      <= ST_IDLE;
                        phase_reg      <= 1'b0;
                        data_out_reg   <= IDLE_WORD;
                        out_active_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_reg;
    assign out_active = out_active_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_tx_gear_sc.sv
// Bench for tx_gear_sc. The reference model is a symbol queue: every accepted
// word contributes its high then low half; whenever the lane is marked active
// the next queued symbol must appear, otherwise the idle word. Buffer occupancy
// is tracked as words accepted minus words whose first half has gone out.
module tb_tx_gear_sc;

    localparam int          DEPTH = 4;
    localparam logic [13:0] IDLE  = 14'h0002;

    logic        clk_250      = 1'b0;
    logic        rst_n        = 1'b0;
    logic        drate_enable = 1'b0;
    logic        in_valid     = 1'b0;
    logic [27:0] data_in      = '0;
    logic        in_ready;
    logic [13:0] data_out;
    logic        out_active;
    logic        underflow;

    tx_gear_sc dut (
        .clk_250      (clk_250),
        .rst_n        (rst_n),
        .drate_enable (drate_enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .data_out     (data_out),
        .out_active   (out_active),
        .underflow    (underflow)
    );

    always #2 clk_250 = ~clk_250;

    typedef struct {
        logic [13:0] sym;
        bit          is_hi;
    } sym_t;

    sym_t sym_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   model_count = 0;
    bit   armed       = 0;
    bit   sync1       = 0;
    bit   sync2       = 0;
    bit   prev_active = 0;
    bit   last_acc    = 0;
    bit   last_hi     = 0;
    bit   saw_full    = 0;
    int   rise_cyc    = -1;
    int   run_len     = 0;
    int   last_run    = 0;
    int   uf_count    = 0;
    int   words_out   = 0;
    int   accepted    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, update the model and compare every output
    task automatic step();
        bit          rst_edge;
        bit          drs;
        bit          acc;
        bit          en;
        bit          exp_uf;
        logic [27:0] din;
        sym_t        s;
        rst_edge = !rst_n;
        drs      = sync2;
        en       = drate_enable;
        din      = data_in;
        acc      = in_valid && armed && (model_count < DEPTH);
        @(posedge clk_250);
        #1;
        cyc++;
        last_acc = 0;
        if (rst_edge) begin
            sync1 = 0; sync2 = 0; armed = 0; model_count = 0;
            sym_q.delete();
            check("rst_data_out", data_out, IDLE);
            check("rst_out_active", out_active, 0);
            check("rst_underflow", underflow, 0);
            prev_active = 0; run_len = 0;
        end else begin
            sync2 = sync1;
            sync1 = en;
            if (!drs) begin
                sym_q.delete();
                model_count = 0;
                armed       = 0;
                check("flush_data_out", data_out, IDLE);
                check("flush_out_active", out_active, 0);
                check("flush_underflow", underflow, 0);
                prev_active = 0; run_len = 0;
            end else begin
                armed = 1;
                if (acc) begin
                    s.sym = din[27:14]; s.is_hi = 1; sym_q.push_back(s);
                    s.sym = din[13:0];  s.is_hi = 0; sym_q.push_back(s);
                    model_count++;
                    accepted++;
                    last_acc = 1;
                end
                if (out_active) begin
                    check("symbol_pending", (sym_q.size() != 0), 1);
                    if (sym_q.size() != 0) begin
                        s = sym_q.pop_front();
                        check("data_out", data_out, s.sym);
                        last_hi = s.is_hi;
                        if (s.is_hi) begin
                            model_count--;
                            words_out++;
                        end
                    end
                    if (!prev_active && rise_cyc < 0) rise_cyc = cyc;
                    run_len++;
                end else begin
                    check("idle_word", data_out, IDLE);
                end
                exp_uf = prev_active && !out_active;
                check("underflow", underflow, exp_uf);
                if (exp_uf) begin
                    check("underflow_empty", sym_q.size() - (acc ? 2 : 0), 0);
                    uf_count++;
                end
                if (prev_active && !out_active) begin
                    last_run = run_len;
                    run_len  = 0;
                end
                prev_active = out_active;
            end
        end
        check("in_ready", in_ready, armed && (model_count < DEPTH));
        if (armed && model_count == DEPTH) saw_full = 1;
    endtask

    // Offer one word until the gearbox takes it (bounded)
    task automatic push_word(input logic [27:0] d);
        in_valid = 1;
        data_in  = d;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) break;
        end
        check("push_accepted", last_acc, 1);
        in_valid = 0;
    endtask

    // Let the lane empty; a lone parked word gets a partner so it can leave
    task automatic drain(input string tag);
        in_valid = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40 && (sym_q.size() > 0 || out_active); i++) step();
            if (sym_q.size() == 2 && !out_active) push_word(28'($urandom));
        end
        for (int i = 0; i < 40 && (sym_q.size() > 0 || out_active); i++) step();
        check({"drained_", tag}, sym_q.size(), 0);
    endtask

    task automatic enable_gear();
        drate_enable = 1;
        for (int i = 0; i < 10 && !armed; i++) step();
        check("enable_ready", in_ready, 1);
    endtask

    initial begin
        int          e1_cyc;
        int          base;
        logic [13:0] saved;

        // Reset
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
        check("idle_not_ready", in_ready, 0);

        // 1: three words on alternate cycles, stream with no gaps
        enable_gear();
        rise_cyc = -1;
        in_valid = 1; data_in = 28'h234_5ABC; step(); in_valid = 0; step();
        in_valid = 1; data_in = 28'hABC_DEF1; step(); e1_cyc = cyc; in_valid = 0; step();
        in_valid = 1; data_in = 28'h5A5_0F0F; step(); in_valid = 0;
        drain("t1");
        check("t1_first_symbol_latency", rise_cyc, e1_cyc + 2);
        check("t1_no_gap_run", last_run, 6);

        // 2: one word waits in FILL; two words give 4 symbols then underflow
        base = uf_count;
        push_word(28'h111_2222);
        repeat (4) step();
        check("t2_fill_threshold", out_active, 0);
        push_word(28'h333_4444);
        drain("t2");
        check("t2_four_symbols", last_run, 4);
        check("t2_one_underflow", uf_count - base, 1);
        step();
        check("t2_underflow_pulse", underflow, 0);

        // 3: in_valid held high with random data over 200 words
        base = words_out;
        saw_full = 0;
        accepted = 0;
        in_valid = 1;
        for (int i = 0; i < 1500 && accepted < 200; i++) begin
            data_in = 28'($urandom);
            step();
        end
        in_valid = 0;
        check("t3_accepted", accepted, 200);
        check("t3_backpressure_seen", saw_full, 1);
        drain("t3");
        check("t3_words_out", words_out - base, 200);

        // 4: disable while a low half is pending, then restart with new data
        in_valid = 1;
        for (int i = 0; i < 50 && !(out_active && last_hi); i++) begin
            data_in = 28'($urandom);
            step();
        end
        check("t4_reached_phase1", out_active && last_hi, 1);
        in_valid = 0;
        drate_enable = 0;
        repeat (3) step();
        check("t4_idle_word", data_out, IDLE);
        check("t4_not_ready", in_ready, 0);
        enable_gear();
        base = words_out;
        push_word(28'hC0F_FEE0);
        push_word(28'hBEE_F001);
        push_word(28'h0DD_BA11);
        drain("t4");
        check("t4_new_words_only", words_out - base, 3);

        // 5: one-edge synchronous reset mid-stream
        in_valid = 1;
        for (int i = 0; i < 50 && !out_active; i++) begin
            data_in = 28'($urandom);
            step();
        end
        in_valid = 0;
        saved = data_out;
        rst_n = 0;
        #1;
        check("t5_no_async_active", out_active, 1);
        check("t5_no_async_data", data_out, saved);
        step();
        rst_n = 1;
        check("t5_reset_ready", in_ready, 0);
        enable_gear();

        // 6: 20 words with random stalls wrap the pointers several times
        base = words_out;
        accepted = 0;
        for (int i = 0; i < 600 && accepted < 20; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            data_in  = 28'($urandom);
            step();
        end
        in_valid = 0;
        check("t6_accepted", accepted, 20);
        drain("t6");
        check("t6_words_out", words_out - base, accepted);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
